// File: rtl/obs_split_seq_50bit.sv
// obs_split_seq_50bit
//   Splits two N-bit GF(2) polynomial operands into even/odd coefficient
//   halves and presents the sub-operand pairs one at a time to an H-bit
//   sub-multiplier, where H = N/2. The overlap stage downstream recombines
//   the sub-products into the full product.
//
//   Build option: OBS_SPLIT_KARA_EN
//     undefined : 4 pairs per operand, idx 0,1,2,3
//     defined   : 3 pairs per operand, idx 0,1,3 (Karatsuba, idx1 = sums)
//
//   Ports
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid/in_ready   operand pair handshake (a_in, b_in)
//     out_valid/out_ready sub-operand pair handshake (op_x, op_y)
//     out_idx             sub-product slot of the presented pair
//     out_last            final pair of the current operand
//     busy                high whenever not IDLE
//
//   state | meaning
//   IDLE  | waiting for an operand pair, outputs zero
//   EMIT  | presenting sub-operand pairs until the last one is taken
module obs_split_seq_50bit #(
  parameter int N = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N/2-1:0]   op_x,
  output logic [N/2-1:0]   op_y,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int H = N / 2;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;

  logic         rdy_en;
  logic         accept;
  logic         xfer;
  logic [H-1:0] a_even, a_odd, b_even, b_odd;
  logic [H-1:0] ae, ao, be, bo;
  logic [1:0]   nxt_idx;
  logic [H-1:0] nxt_x, nxt_y;

  always_comb begin
    a_even = '0;
    a_odd  = '0;
    b_even = '0;
    b_odd  = '0;
    for (int k = 0; k < H; k++) begin
      a_even[k] = a_in[2*k];
      a_odd[k]  = a_in[2*k+1];
      b_even[k] = b_in[2*k];
      b_odd[k]  = b_in[2*k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rdy_en keeps in_ready low during reset and through the first edge after it
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
          accept    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          xfer = 1'b1;
          if (out_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef OBS_SPLIT_KARA_EN
  assign nxt_idx = (out_idx == 2'd0) ? 2'd1 : 2'd3;
`else
  assign nxt_idx = out_idx + 2'd1;
`endif

  // Pair that follows the one currently on the outputs
  always_comb begin
    nxt_x = ae;
    nxt_y = be;
    case (nxt_idx)
`ifdef OBS_SPLIT_KARA_EN
      2'd1: begin nxt_x = ae ^ ao; nxt_y = be ^ bo; end
`else
      2'd1: begin nxt_x = ae;      nxt_y = bo;      end
      2'd2: begin nxt_x = ao;      nxt_y = be;      end
`endif
      2'd3: begin nxt_x = ao;      nxt_y = bo;      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      ae       <= '0;
      ao       <= '0;
      be       <= '0;
      bo       <= '0;
      op_x     <= '0;
      op_y     <= '0;
      out_idx  <= 2'd0;
      out_last <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        ae       <= a_even;
        ao       <= a_odd;
        be       <= b_even;
        bo       <= b_odd;
        op_x     <= a_even;
        op_y     <= b_even;
        out_idx  <= 2'd0;
        out_last <= 1'b0;
      end else if (xfer) begin
        if (out_last) begin
          op_x     <= '0;
          op_y     <= '0;
          out_idx  <= 2'd0;
          out_last <= 1'b0;
        end else begin
          op_x     <= nxt_x;
          op_y     <= nxt_y;
          out_idx  <= nxt_idx;
          out_last <= (nxt_idx == 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_obs_split_seq_50bit.sv
// Testbench for obs_split_seq_50bit: directed sequences plus random operands
// reassembled through a reference sub-multiplier and overlap stage.
module tb_obs_split_seq_50bit;

  localparam int N = 50;
  localparam int H = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in, b_in;
  logic         out_valid;
  logic         out_ready;
  logic [H-1:0] op_x, op_y;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [H-1:0] got_x   [0:3];
  logic [H-1:0] got_y   [0:3];
  logic [1:0]   got_idx [0:3];
  int           ncnt;

`ifdef OBS_SPLIT_KARA_EN
  localparam int EXP_CNT = 3;
`else
  localparam int EXP_CNT = 4;
`endif

  obs_split_seq_50bit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_x      (op_x),
    .op_y      (op_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] clmul(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] r = '0;
    for (int i = 0; i < 64; i++)
      if (y[i]) r = r ^ ({64'd0, x} << i);
    return r;
  endfunction

  function automatic logic [H-1:0] half(input logic [N-1:0] v, input int odd);
    logic [H-1:0] r = '0;
    for (int k = 0; k < H; k++) r[k] = v[2*k+odd];
    return r;
  endfunction

  // Coefficient k of a polynomial in x^2 lands on bit 2k
  function automatic logic [127:0] spread(input logic [127:0] p);
    logic [127:0] r = '0;
    for (int k = 0; k < 64; k++) r[2*k] = p[k];
    return r;
  endfunction

  function automatic int seq_idx(input int n);
`ifdef OBS_SPLIT_KARA_EN
    return (n == 2) ? 3 : n;
`else
    return n;
`endif
  endfunction

  task automatic exp_pair(input logic [N-1:0] a, input logic [N-1:0] b, input int idx,
                          output logic [H-1:0] x, output logic [H-1:0] y);
    logic [H-1:0] aev, aod, bev, bod;
    aev = half(a, 0); aod = half(a, 1);
    bev = half(b, 0); bod = half(b, 1);
    case (idx)
      0: begin x = aev; y = bev; end
`ifdef OBS_SPLIT_KARA_EN
      1: begin x = aev ^ aod; y = bev ^ bod; end
`else
      1: begin x = aev; y = bod; end
      2: begin x = aod; y = bev; end
`endif
      default: begin x = aod; y = bod; end
    endcase
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("send_in_ready", {127'd0, in_ready}, 128'd1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle after acceptance; collects pairs, checks them and the
  // reassembled product, and returns one cycle after the last transfer.
  task automatic drain(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                       input bit rnd, input bit poke, input bit timing);
    int cyc = 0;
    bit done = 0;
    bit held = 0;
    logic [H-1:0] hx, hy, ex, ey;
    logic [1:0]   hi;
    logic         hl;
    logic [127:0] p [0:3];
    logic [127:0] mid, prod;
    ncnt = 0;
    for (int i = 0; i < 4; i++) p[i] = '0;
    while (!done && cyc < 200) begin
      cyc++;
      out_ready = (cyc <= stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      in_valid  = poke && (cyc == 1);
      if (poke && cyc == 1) begin
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
      end
      chk("emit_out_valid", {127'd0, out_valid}, 128'd1);
      chk("emit_in_ready", {127'd0, in_ready}, 128'd0);
      chk("emit_busy", {127'd0, busy}, 128'd1);
      if (held) begin
        chk("stall_x", {103'd0, op_x}, {103'd0, hx});
        chk("stall_y", {103'd0, op_y}, {103'd0, hy});
        chk("stall_idx", {126'd0, out_idx}, {126'd0, hi});
        chk("stall_last", {127'd0, out_last}, {127'd0, hl});
      end
      if (out_ready) begin
        exp_pair(a, b, seq_idx(ncnt), ex, ey);
        chk("pair_idx", {126'd0, out_idx}, 128'(seq_idx(ncnt)));
        chk("pair_x", {103'd0, op_x}, {103'd0, ex});
        chk("pair_y", {103'd0, op_y}, {103'd0, ey});
        chk("pair_last", {127'd0, out_last}, {127'd0, ncnt == EXP_CNT - 1});
        if (timing) chk("pair_cycle", 128'(cyc), 128'(ncnt + 1));
        got_x[ncnt]   = op_x;
        got_y[ncnt]   = op_y;
        got_idx[ncnt] = out_idx;
        p[out_idx]    = clmul({39'd0, op_x}, {39'd0, op_y});
        ncnt++;
        if (out_last || ncnt == 4) done = 1;
        held = 0;
      end else begin
        held = 1;
        hx = op_x; hy = op_y; hi = out_idx; hl = out_last;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!done) chk("drain_timeout", 128'd0, 128'd1);
    chk("xfer_count", 128'(ncnt), 128'(EXP_CNT));
    chk("idle_in_ready", {127'd0, in_ready}, 128'd1);
    chk("idle_out_valid", {127'd0, out_valid}, 128'd0);
    chk("idle_busy", {127'd0, busy}, 128'd0);
    chk("idle_data", {76'd0, op_x, op_y, out_idx, out_last}, 128'd0);
`ifdef OBS_SPLIT_KARA_EN
    mid = p[1] ^ p[0] ^ p[3];
`else
    mid = p[1] ^ p[2];
`endif
    prod = spread(p[0]) ^ (spread(mid) << 1) ^ (spread(p[3]) << 2);
    chk("product", prod, clmul({14'd0, a}, {14'd0, b}));
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    tick();
    chk("rst_outputs", {72'd0, in_ready, out_valid, busy, op_x, op_y, out_idx, out_last}, 128'd0);
    rst_n = 1'b1;
    chk("rst_rel_in_ready_low", {127'd0, in_ready}, 128'd0);
    tick();
    chk("rst_rel_in_ready", {127'd0, in_ready}, 128'd1);

`ifndef OBS_SPLIT_KARA_EN
    send(50'h2AAAAAAAAAAAA, 50'h1555555555555);
    drain(50'h2AAAAAAAAAAAA, 50'h1555555555555, 0, 0, 0, 1);
    chk("alt_x0", {103'd0, got_x[0]}, 128'h0);
    chk("alt_y0", {103'd0, got_y[0]}, 128'h1FFFFFF);
    chk("alt_x1", {103'd0, got_x[1]}, 128'h0);
    chk("alt_y1", {103'd0, got_y[1]}, 128'h0);
    chk("alt_x2", {103'd0, got_x[2]}, 128'h1FFFFFF);
    chk("alt_y2", {103'd0, got_y[2]}, 128'h1FFFFFF);
    chk("alt_x3", {103'd0, got_x[3]}, 128'h1FFFFFF);
    chk("alt_y3", {103'd0, got_y[3]}, 128'h0);

    send(50'h1, 50'h2);
    drain(50'h1, 50'h2, 3, 0, 0, 0);
    chk("stl_x0", {103'd0, got_x[0]}, 128'h1);
    chk("stl_y0", {103'd0, got_y[0]}, 128'h0);
    chk("stl_x1", {103'd0, got_x[1]}, 128'h1);
    chk("stl_y1", {103'd0, got_y[1]}, 128'h1);
    chk("stl_x2", {103'd0, got_x[2]}, 128'h0);
    chk("stl_y2", {103'd0, got_y[2]}, 128'h0);
    chk("stl_x3", {103'd0, got_x[3]}, 128'h0);
    chk("stl_y3", {103'd0, got_y[3]}, 128'h1);
`else
    send(50'h3, 50'h3);
    drain(50'h3, 50'h3, 0, 0, 0, 1);
    chk("kara_idx2", {126'd0, got_idx[2]}, 128'd3);
    chk("kara_x0", {103'd0, got_x[0]}, 128'h1);
    chk("kara_y0", {103'd0, got_y[0]}, 128'h1);
    chk("kara_x1", {103'd0, got_x[1]}, 128'h0);
    chk("kara_y1", {103'd0, got_y[1]}, 128'h0);
    chk("kara_x3", {103'd0, got_x[2]}, 128'h1);
    chk("kara_y3", {103'd0, got_y[2]}, 128'h1);
`endif

    // New operand offered during EMIT must be ignored
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    send(ra, rb);
    drain(ra, rb, 0, 0, 1, 1);

    // Reset after the idx1 transfer abandons the operand
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    send(ra, rb);
    out_ready = 1'b1;
    tick();
    chk("mid_rst_idx1", {126'd0, out_idx}, 128'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_outputs", {72'd0, in_ready, out_valid, busy, op_x, op_y, out_idx, out_last}, 128'd0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("mid_rst_rel_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_no_emit", {127'd0, out_valid}, 128'd0);
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    send(ra, rb);
    drain(ra, rb, 0, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t == 0) begin ra = '1; rb = '1; end
      send(ra, rb);
      drain(ra, rb, 0, 1, 0, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obs_split_seq_50bit.md
OBS_SPLIT_SEQ_50BIT -- requirements
Module: obs_split_seq_50bit

Interface
REQ-001 The block SHALL have parameter N, default 50: operand width (even); half width H = N/2.
REQ-002 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1: operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-006 The block SHALL have ports a_in and b_in, input, N each: polynomial operands over GF(2), bit i = coefficient of x^i.
REQ-007 The block SHALL have port out_valid, output, 1: sub-operand pair presented.
REQ-008 The block SHALL have port out_ready, input, 1: downstream H-bit sub-multiplier accepts the pair.
REQ-009 The block SHALL have ports op_x and op_y, output, H each: sub-operands.
REQ-010 The block SHALL have port out_idx, output, 2: sub-product slot, 0=even*even, 1=even*odd, 2=odd*even, 3=odd*odd; this is the slot order of the overlap stage's inputs 1..4.
REQ-011 The block SHALL have port out_last, output, 1: high with the final pair of an operand.
REQ-012 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 The block SHALL perform the odd-even split as follows.
- Ae[k]=a_in[2k], Ao[k]=a_in[2k+1], k=0..H-1.
- Be and Bo are formed from b_in in the same way.
REQ-014 The block SHALL use two FSM states, IDLE and EMIT.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 On in_valid&&in_ready, the block SHALL register Ae, Ao, Be and Bo, set idx=0 and move to EMIT.
REQ-017 In EMIT, in_ready SHALL be 0 and out_valid SHALL be 1; in_valid SHALL be ignored.
REQ-018 In EMIT, the pair per idx SHALL be:
- 0: (Ae,Be)
- 1: (Ae,Bo)
- 2: (Ao,Be)
- 3: (Ao,Bo)
REQ-019 On out_valid&&out_ready, idx SHALL advance; out_last=1 only when idx=3.
REQ-020 When a transfer with out_last=1 completes, the FSM SHALL return to IDLE.
REQ-021 The first out_valid SHALL appear the cycle after input acceptance (latency 1); the next operand can be accepted no earlier than the cycle after the last transfer.
REQ-022 While out_valid=1 and out_ready=0, op_x, op_y, out_idx and out_last SHALL remain stable.
REQ-023 out_ready held high SHALL give one transfer per cycle, i.e. 4 consecutive cycles per operand.
REQ-024 op_x, op_y, out_idx and out_last SHALL be registered outputs, with no combinational path from out_ready to data.
REQ-025 In IDLE, op_x, op_y, out_idx and out_last SHALL hold 0.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL enter IDLE.
- Outputs: out_valid=0, busy=0, in_ready=0, op_x=0, op_y=0, out_idx=0, out_last=0.
- Operand registers cleared.
REQ-027 The block SHALL set in_ready=1 on the first edge after rst_n returns to 1.
REQ-028 Reset asserted mid-EMIT SHALL abandon the operand silently; no further pairs SHALL be emitted for it.

Configuration
REQ-029 The block SHALL support the macro OBS_SPLIT_KARA_EN, with this behaviour when defined:
- 3-pair Karatsuba sequence, idx 0, 1, 3.
- Pair for idx 1 = (Ae^Ao, Be^Bo).
- out_last with idx 3; 3 transfers per operand.
- Downstream recovers the middle term as P1^P0^P3.
REQ-030 Without OBS_SPLIT_KARA_EN, the block SHALL emit the 4-pair sequence of REQ-018; idx 2 never occurs only when the macro is defined.

Verification
REQ-031 The bench SHALL apply a_in=50'h2AAAAAAAAAAAA, b_in=50'h1555555555555, out_ready=1, and check:
- idx0 (0,1FFFFFF), idx1 (0,0), idx2 (1FFFFFF,1FFFFFF), idx3 (1FFFFFF,0).
- out_last on cycle 4 after acceptance; in_ready returns 1 the cycle after.
REQ-032 The bench SHALL apply a_in=1, b_in=2, hold out_ready=0 for 3 cycles, then set it to 1, and check:
- idx0 (1,0) held stable for all 4 cycles.
- Then idx1 (1,1), idx2 (0,0), idx3 (0,1).
REQ-033 The bench SHALL pulse in_valid with a new operand during EMIT and check that it is ignored: emitted pairs are unchanged and in_ready=0.
REQ-034 The bench SHALL assert rst_n=0 after the idx1 transfer and check:
- Next cycle, all outputs are 0.
- After release, a fresh operand's sequence starts at idx0.
REQ-035 With OBS_SPLIT_KARA_EN defined, the bench SHALL apply a_in=50'h3, b_in=50'h3 and check:
- Pairs idx0 (1,1), idx1 (0,0), idx3 (1,1).
- Exactly 3 transfers.
REQ-036 The bench SHALL feed random operands through a reference sub-multiplier and the overlap stage, and check the reassembled 99-bit result equals the GF(2) product a_in*b_in, in both configurations.
